// File: rtl/mul_cell_arbiter.sv
// rtl/mul_cell_arbiter.sv - two-requester round-robin front end for an external two-stage multiply cell

module mul_cell_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             r0_valid,
  output logic             r0_ready,
  input  logic [31:0]      r0_src1,
  input  logic [31:0]      r0_src2,
  input  logic             r0_src1_signed,
  input  logic             r0_src2_signed,
  input  logic             r0_hi,
  input  logic             r1_valid,
  output logic             r1_ready,
  input  logic [31:0]      r1_src1,
  input  logic [31:0]      r1_src2,
  input  logic             r1_src1_signed,
  input  logic             r1_src2_signed,
  input  logic             r1_hi,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [31:0]      rsp_data,
  output logic [31:0]      mul_src1,
  output logic [31:0]      mul_src2,
  output logic             mul_src1_signed,
  output logic             mul_src2_signed,
  output logic             mul_m_en,
  output logic             mul_a_en,
  input  logic [63:0]      mul_result,
  input  logic             flush,
  output logic [CNT_W-1:0] ops_issued
);

  // Pipeline tracking for the cell's M (operand) and A (product) registers
  logic             r_v_m, r_id_m, r_hi_m;
  logic             r_v_a, r_id_a, r_hi_a;
  logic             r_last;
  logic [CNT_W-1:0] r_ops;

  logic w_gnt;
  logic w_hi;
  logic w_take;
  logic w_accept;

  // Round-robin choice: contention goes to whoever was not served last; idle selects requester 0
  always_comb begin
    w_gnt = 1'b0;
    if (r0_valid && r1_valid) begin
      w_gnt = ~r_last;
    end else if (r1_valid) begin
      w_gnt = 1'b1;
    end
  end

  // A frees when its result is consumed; M frees when empty or when A can take it
  assign mul_a_en = ~r_v_a | rsp_ready;
  assign mul_m_en = ~r_v_m | mul_a_en;

  // reset_n gates ready so nothing is accepted while the block is held in reset
  assign w_take   = mul_m_en & ~flush & reset_n;
  assign r0_ready = ~w_gnt & w_take;
  assign r1_ready = w_gnt & w_take;
  assign w_accept = (r0_valid & r0_ready) | (r1_valid & r1_ready);

  // Operands flow straight from the granted requester into the cell's input register
  always_comb begin
    mul_src1        = r0_src1;
    mul_src2        = r0_src2;
    mul_src1_signed = r0_src1_signed;
    mul_src2_signed = r0_src2_signed;
    w_hi            = r0_hi;
    if (w_gnt) begin
      mul_src1        = r1_src1;
      mul_src2        = r1_src2;
      mul_src1_signed = r1_src1_signed;
      mul_src2_signed = r1_src2_signed;
      w_hi            = r1_hi;
    end
  end

  assign rsp_valid  = r_v_a;
  assign rsp_id     = r_id_a;
  assign rsp_data   = r_hi_a ? mul_result[63:32] : mul_result[31:0];
  assign ops_issued = r_ops;

  // Stage valid/tag registers mirror the cell's enables; flush empties both stages
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_v_m  <= 1'b0;
      r_id_m <= 1'b0;
      r_hi_m <= 1'b0;
      r_v_a  <= 1'b0;
      r_id_a <= 1'b0;
      r_hi_a <= 1'b0;
    end else if (flush) begin
      r_v_m <= 1'b0;
      r_v_a <= 1'b0;
    end else begin
      if (mul_m_en) begin
        r_v_m  <= w_accept;
        r_id_m <= w_gnt;
        r_hi_m <= w_hi;
      end
      if (mul_a_en) begin
        r_v_a  <= r_v_m;
        r_id_a <= r_id_m;
        r_hi_a <= r_hi_m;
      end
    end
  end

  // Round-robin pointer and issued-operation counter advance only on an accept
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last <= 1'b1;
      r_ops  <= '0;
    end else if (w_accept) begin
      r_last <= w_gnt;
      r_ops  <= r_ops + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mul_cell_arbiter.sv
// tb/tb_mul_cell_arbiter.sv - directed-vector bench for mul_cell_arbiter with a behavioural multiply cell

module tb_mul_cell_arbiter;

  logic        clk;
  logic        reset_n;
  logic        r0_valid, r1_valid;
  logic [31:0] r0_src1, r0_src2, r1_src1, r1_src2;
  logic        r0_src1_signed, r0_src2_signed, r1_src1_signed, r1_src2_signed;
  logic        r0_hi, r1_hi;
  logic        rsp_ready;
  logic        flush;
  logic [63:0] mul_result;

  logic        r0_ready, r1_ready, rsp_valid, rsp_id;
  logic [31:0] rsp_data, mul_src1, mul_src2;
  logic        mul_src1_signed, mul_src2_signed, mul_m_en, mul_a_en;
  logic [15:0] ops_issued;

  logic        r0_ready4, r1_ready4, rsp_valid4, rsp_id4;
  logic [31:0] rsp_data4, mul_src1_4, mul_src2_4;
  logic        mul_src1_signed4, mul_src2_signed4, mul_m_en4, mul_a_en4;
  logic [3:0]  ops_issued4;

  int n_vec;
  int n_miss;

  mul_cell_arbiter #(.CNT_W(16)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_src1(r0_src1), .r0_src2(r0_src2),
    .r0_src1_signed(r0_src1_signed), .r0_src2_signed(r0_src2_signed), .r0_hi(r0_hi),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_src1(r1_src1), .r1_src2(r1_src2),
    .r1_src1_signed(r1_src1_signed), .r1_src2_signed(r1_src2_signed), .r1_hi(r1_hi),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .mul_src1(mul_src1), .mul_src2(mul_src2),
    .mul_src1_signed(mul_src1_signed), .mul_src2_signed(mul_src2_signed),
    .mul_m_en(mul_m_en), .mul_a_en(mul_a_en), .mul_result(mul_result),
    .flush(flush), .ops_issued(ops_issued)
  );

  mul_cell_arbiter #(.CNT_W(4)) u_dut4 (
    .clk(clk), .reset_n(reset_n),
    .r0_valid(r0_valid), .r0_ready(r0_ready4), .r0_src1(r0_src1), .r0_src2(r0_src2),
    .r0_src1_signed(r0_src1_signed), .r0_src2_signed(r0_src2_signed), .r0_hi(r0_hi),
    .r1_valid(r1_valid), .r1_ready(r1_ready4), .r1_src1(r1_src1), .r1_src2(r1_src2),
    .r1_src1_signed(r1_src1_signed), .r1_src2_signed(r1_src2_signed), .r1_hi(r1_hi),
    .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready), .rsp_id(rsp_id4), .rsp_data(rsp_data4),
    .mul_src1(mul_src1_4), .mul_src2(mul_src2_4),
    .mul_src1_signed(mul_src1_signed4), .mul_src2_signed(mul_src2_signed4),
    .mul_m_en(mul_m_en4), .mul_a_en(mul_a_en4), .mul_result(mul_result),
    .flush(flush), .ops_issued(ops_issued4)
  );

  // Behavioural two-stage multiply cell driven by the primary instance
  logic [31:0] c_src1, c_src2;
  logic        c_s1, c_s2;
  logic [63:0] c_ext1, c_ext2;

  assign c_ext1 = {{32{c_s1 & c_src1[31]}}, c_src1};
  assign c_ext2 = {{32{c_s2 & c_src2[31]}}, c_src2};

  always @(posedge clk) begin
    if (mul_m_en) begin
      c_src1 <= mul_src1;
      c_src2 <= mul_src2;
      c_s1   <= mul_src1_signed;
      c_s2   <= mul_src2_signed;
    end
    if (mul_a_en) begin
      mul_result <= c_ext1 * c_ext2;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    r0_valid = 0; r1_valid = 0;
    r0_src1 = 0; r0_src2 = 0; r1_src1 = 0; r1_src2 = 0;
    r0_src1_signed = 0; r0_src2_signed = 0; r1_src1_signed = 0; r1_src2_signed = 0;
    r0_hi = 0; r1_hi = 0; flush = 0; rsp_ready = 1;
  endtask

  int          exp_cid [4] = '{0, 1, 0, 1};
  logic [31:0] exp_cdat[4] = '{32'd6, 32'd20, 32'd6, 32'd20};
  int          bp_rdy  [9] = '{0, 0, 0, 0, 0, 1, 1, 1, 1};
  int          bp_r0rdy[6] = '{1, 1, 0, 0, 0, 1};
  int          bp_rv   [9] = '{0, 0, 1, 1, 1, 1, 1, 1, 0};
  logic [31:0] bp_dat  [9] = '{32'd0, 32'd0, 32'd30, 32'd30, 32'd30, 32'd30, 32'd33, 32'd36, 32'd0};

  initial begin
    n_vec = 0;
    n_miss = 0;

    // Reset behaviour with a pending request
    reset_n = 0;
    clear_inputs();
    r0_valid = 1; r0_src1 = 3; r0_src2 = 5;
    repeat (3) step();
    check_vec("rst_r0_ready", r0_ready, 0);
    check_vec("rst_rsp_valid", rsp_valid, 0);
    check_vec("rst_m_en", mul_m_en, 1);
    check_vec("rst_a_en", mul_a_en, 1);
    check_vec("rst_rsp_data", rsp_data, 15);
    check_vec("rst_ops", ops_issued, 0);
    reset_n = 1;
    r0_valid = 0;
    #1;
    check_vec("rel_rsp_valid", rsp_valid, 0);
    step();

    // Single unsigned operation
    clear_inputs();
    r0_valid = 1; r0_src1 = 7; r0_src2 = 6;
    #1 check_vec("t1_r0_ready", r0_ready, 1);
    step();
    r0_valid = 0;
    #1 check_vec("t1_c1_valid", rsp_valid, 0);
    step();
    check_vec("t1_valid", rsp_valid, 1);
    check_vec("t1_id", rsp_id, 0);
    check_vec("t1_data", rsp_data, 42);
    check_vec("t1_ops", ops_issued, 1);
    step();
    check_vec("t1_c3_valid", rsp_valid, 0);

    // Signed high/low halves back to back on r1
    clear_inputs();
    r1_valid = 1; r1_src1 = 32'hFFFF_FFFF; r1_src2 = 2;
    r1_src1_signed = 1; r1_src2_signed = 1; r1_hi = 1;
    #1 check_vec("t2_r1_ready_a", r1_ready, 1);
    step();
    r1_hi = 0;
    #1 check_vec("t2_r1_ready_b", r1_ready, 1);
    step();
    r1_valid = 0;
    #1;
    check_vec("t2_valid_hi", rsp_valid, 1);
    check_vec("t2_id_hi", rsp_id, 1);
    check_vec("t2_data_hi", rsp_data, 32'hFFFF_FFFF);
    step();
    check_vec("t2_valid_lo", rsp_valid, 1);
    check_vec("t2_id_lo", rsp_id, 1);
    check_vec("t2_data_lo", rsp_data, 32'hFFFF_FFFE);
    step();
    check_vec("t2_done", rsp_valid, 0);
    check_vec("t2_ops", ops_issued, 3);

    // Reset in the middle of an operation drops it
    clear_inputs();
    r0_valid = 1; r0_src1 = 9; r0_src2 = 9;
    #1 check_vec("t3_r0_ready", r0_ready, 1);
    step();
    r0_valid = 0;
    reset_n = 0;
    #1;
    check_vec("t3_rst_valid", rsp_valid, 0);
    check_vec("t3_rst_ops", ops_issued, 0);
    step();
    reset_n = 1;
    for (int c = 0; c < 3; c++) begin
      #1 check_vec("t3_post_valid", rsp_valid, 0);
      step();
    end

    // Contention: alternating grants starting with requester 0
    clear_inputs();
    r0_src1 = 2; r0_src2 = 3; r1_src1 = 4; r1_src2 = 5;
    for (int c = 0; c < 6; c++) begin
      r0_valid = (c < 4);
      r1_valid = (c < 4);
      #1;
      if (c < 4) begin
        check_vec("t4_r0_ready", r0_ready, (exp_cid[c] == 0));
        check_vec("t4_r1_ready", r1_ready, (exp_cid[c] == 1));
      end
      if (c >= 2) begin
        check_vec("t4_valid", rsp_valid, 1);
        check_vec("t4_id", rsp_id, exp_cid[c-2]);
        check_vec("t4_data", rsp_data, exp_cdat[c-2]);
      end
      step();
    end
    check_vec("t4_done", rsp_valid, 0);
    check_vec("t4_ops", ops_issued, 4);

    // Backpressure, then drain with a simultaneous accept
    clear_inputs();
    begin
      int k;
      k = 0;
      for (int c = 0; c < 9; c++) begin
        rsp_ready = (bp_rdy[c] != 0);
        r0_valid = (c <= 5);
        r0_src1 = 10 + k;
        r0_src2 = 3;
        #1;
        if (c <= 5) check_vec("t5_r0_ready", r0_ready, bp_r0rdy[c]);
        check_vec("t5_valid", rsp_valid, bp_rv[c]);
        if (bp_rv[c] != 0) check_vec("t5_data", rsp_data, bp_dat[c]);
        if (r0_valid && r0_ready) k++;
        step();
      end
    end
    check_vec("t5_ops", ops_issued, 7);

    // Flush with both stages occupied
    clear_inputs();
    r0_valid = 1; r0_src1 = 5; r0_src2 = 5;
    #1 check_vec("t6_r0_ready_a", r0_ready, 1);
    step();
    r0_src1 = 6;
    #1 check_vec("t6_r0_ready_b", r0_ready, 1);
    step();
    r0_src1 = 7;
    flush = 1;
    #1;
    check_vec("t6_flush_ready", r0_ready, 0);
    check_vec("t6_pre_valid", rsp_valid, 1);
    check_vec("t6_pre_data", rsp_data, 25);
    step();
    flush = 0;
    r0_valid = 0;
    #1;
    check_vec("t6_post_valid", rsp_valid, 0);
    check_vec("t6_ops", ops_issued, 9);
    step();
    check_vec("t6_post_valid2", rsp_valid, 0);

    // Counter wrap: eight more accepts brings the total to 17
    clear_inputs();
    r0_valid = 1; r0_src1 = 1; r0_src2 = 1;
    for (int c = 0; c < 8; c++) begin
      #1 check_vec("t7_r0_ready", r0_ready, 1);
      step();
    end
    r0_valid = 0;
    #1;
    check_vec("t7_ops16", ops_issued, 17);
    check_vec("t7_ops4", ops_issued4, 1);
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/mul_cell_arbiter.md
MUL_CELL_ARBITER -- requirements
Module: mul_cell_arbiter

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the issued-operation counter.
REQ-002 SHALL have port clk, input, 1, the single clock for all state.
REQ-003 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have ports r0_valid/r1_valid, input, 1 each, requester n has an operation pending.
REQ-005 SHALL have ports r0_ready/r1_ready, output, 1 each, operation of requester n is accepted this cycle.
REQ-006 SHALL have ports r0_src1/r0_src2/r1_src1/r1_src2, input, 32 each, operands.
REQ-007 SHALL have ports rn_src1_signed/rn_src2_signed (n=0,1), input, 1 each, operand signedness.
REQ-008 SHALL have ports r0_hi/r1_hi, input, 1 each, 1 selects product bits [63:32] and 0 selects bits [31:0].
REQ-009 SHALL have ports rsp_valid (output, 1), rsp_ready (input, 1), rsp_id (output, 1, index of the requester that owns the result) and rsp_data (output, 32, selected product half).
REQ-010 SHALL have ports mul_src1/mul_src2 (output, 32), mul_src1_signed/mul_src2_signed (output, 1), mul_m_en (output, 1, cell input-register enable), mul_a_en (output, 1, cell output-register enable) and mul_result (input, 64, cell registered product).
REQ-011 SHALL have port flush, input, 1, synchronous discard of all in-flight operations.
REQ-012 SHALL have port ops_issued, output, CNT_W, count of accepted operations.

Function
REQ-013 SHALL treat the external cell as a two-stage pipe: operands are captured at an edge where mul_m_en=1 (stage M), and the product is captured at an edge where mul_a_en=1 (stage A).
REQ-014 SHALL track per stage a valid bit, tag id and hi flag (v_m/id_m/hi_m, v_a/id_a/hi_a).
REQ-015 SHALL drive mul_a_en = ~v_a | rsp_ready, and mul_m_en = ~v_m | mul_a_en.
REQ-016 SHALL drive mul_src*/mul_src*_signed combinationally from the granted requester; when no request is valid, it SHALL select requester 0.
REQ-017 SHALL arbitrate round-robin with pointer last: if both requesters are valid, grant goes to the requester that is not last; if only one is valid, that requester is granted.
REQ-018 SHALL assert rn_ready = grant_n & mul_m_en & ~flush; an accept is rn_valid & rn_ready.
REQ-019 On an accept, SHALL set last to the accepted index, and ops_issued SHALL increment by 1, wrapping at 2^CNT_W-1 to 0.
REQ-020 At an edge with mul_m_en=1, SHALL load v_m <= accept, id_m <= accepted index and hi_m <= accepted rn_hi.
REQ-021 At an edge with mul_a_en=1, SHALL load v_a <= v_m, id_a <= id_m and hi_a <= hi_m.
REQ-022 SHALL assert rsp_valid = v_a, with rsp_id = id_a and rsp_data = hi_a ? mul_result[63:32] : mul_result[31:0].
REQ-023 Latency: an operation accepted in cycle N SHALL produce rsp_valid in cycle N+2 when not stalled; sustained throughput SHALL be one operation per cycle.
REQ-024 Backpressure: when rsp_valid=1 and rsp_ready=0, SHALL hold the A stage and rsp_data stable, and SHALL hold the M stage if v_m=1; when v_m=0, one new operation SHALL still be accepted into M.
REQ-025 Simultaneous drain and accept in one cycle SHALL lose no operation.
REQ-026 While flush=1, SHALL deassert both rn_ready; the next edge SHALL clear v_m and v_a, and ops_issued SHALL be unchanged.
REQ-027 SHALL keep requester operands, signedness and hi unchanged while rn_valid=1 and rn_ready=0; the block SHALL NOT latch operands itself.

Reset
REQ-028 reset_n=0 SHALL asynchronously clear v_m, v_a, id_m, id_a, hi_m, hi_a, ops_issued=0 and last=1, so that requester 0 wins the first contention.
REQ-029 During reset, SHALL hold outputs at rsp_valid=0, r0_ready=0, r1_ready=0, mul_m_en=1, mul_a_en=1 and rsp_data=mul_result[31:0].
REQ-030 Reset asserted mid-operation SHALL drop all in-flight results; after release, no rsp_valid SHALL occur until a new accept.

Verification
REQ-031 Single operation: r0 with src1=7, src2=6, unsigned, hi=0, rsp_ready=1 -> r0_ready in cycle 0; rsp_valid, rsp_id=0, rsp_data=42 in cycle 2; ops_issued=1.
REQ-032 Signed high half: r1 with src1=0xFFFFFFFF (signed), src2=2 (signed), hi=1 -> rsp_id=1 and rsp_data=0xFFFFFFFF; the same operands with hi=0 -> 0xFFFFFFFE.
REQ-033 Contention: r0 and r1 both valid for 4 cycles after reset -> grants 0,1,0,1 and responses with rsp_id 0,1,0,1 in order, each 2 cycles after its accept.
REQ-034 Backpressure: stream on r0 with rsp_ready=0 for 5 cycles -> exactly 2 accepts, then rn_ready=0, rsp_data stable; releasing rsp_ready -> both results delivered in order with none lost or duplicated.
REQ-035 Flush: flush=1 for one cycle with v_m=v_a=1 -> no rsp_valid the following cycle, and ops_issued unchanged.
REQ-036 Counter wrap: CNT_W=4, 17 accepts -> ops_issued=1.
